// File: rtl/secuenciador_alu_if.sv
// Front-panel bus: switches/buttons in, ALU operands and display out.
// The panel side drives the master modport and the sequencer uses the slave modport.
interface secuenciador_alu_if #(
  parameter int ANCHO    = 8,
  parameter int ANCHO_OP = 6
);
  logic [ANCHO-1:0]    entrada;
  logic                boton_a;
  logic                boton_b;
  logic                boton_op;
  logic                boton_exec;
  logic [ANCHO-1:0]    resultado_alu;
  logic [ANCHO-1:0]    a;
  logic [ANCHO-1:0]    b;
  logic [ANCHO_OP-1:0] op;
  logic [ANCHO-1:0]    resultado;
  logic                valido;
  logic [2:0]          estado;

  modport master (
    output entrada,
    output boton_a,
    output boton_b,
    output boton_op,
    output boton_exec,
    output resultado_alu,
    input  a,
    input  b,
    input  op,
    input  resultado,
    input  valido,
    input  estado
  );

  modport slave (
    input  entrada,
    input  boton_a,
    input  boton_b,
    input  boton_op,
    input  boton_exec,
    input  resultado_alu,
    output a,
    output b,
    output op,
    output resultado,
    output valido,
    output estado
  );
endinterface

// File: rtl/secuenciador_alu.sv
// Clocked load-A / load-B / load-OP / execute sequencer for the ALU.
// Defining DEBOUNCE_EN adds a per-button stability filter of DEB_CICLOS clocks.
module secuenciador_alu #(
  parameter int ANCHO      = 8,
  parameter int ANCHO_OP   = 6,
  parameter int DEB_CICLOS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  secuenciador_alu_if.slave bus
);

  typedef enum logic [2:0] {
    CARGA_A  = 3'd0,
    CARGA_B  = 3'd1,
    CARGA_OP = 3'd2,
    LISTO    = 3'd3,
    EJEC     = 3'd4,
    MUESTRA  = 3'd5
  } estado_t;

  // Bit order: 0=A, 1=B, 2=OP, 3=EXEC
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] nivel;
  logic [3:0] pulso;

  assign btn_raw = {bus.boton_exec, bus.boton_op,
                    bus.boton_b, bus.boton_a};

  // Two-stage synchroniser feeding the edge detector
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = nivel;
  end

  // Synchroniser and previous-level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CICLOS + 1);

  logic [3:0]         filt_q, filt_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;

  // Filtered level flips after DEB_CICLOS clocks of disagreement
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CICLOS - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counters and filtered levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign nivel = filt_q;
`else
  assign nivel = sync2_q;
`endif

  assign pulso = nivel & ~prev_q;

  logic pulso_a, pulso_b, pulso_op, pulso_exec;

  assign pulso_a    = pulso[0];
  assign pulso_b    = pulso[1];
  assign pulso_op   = pulso[2];
  assign pulso_exec = pulso[3];

  estado_t             estado_q, estado_d;
  logic [ANCHO-1:0]    a_q, a_d;
  logic [ANCHO-1:0]    b_q, b_d;
  logic [ANCHO_OP-1:0] op_q, op_d;
  logic [ANCHO-1:0]    res_q, res_d;
  logic                valido_q, valido_d;

  // Next state and register loads; only the expected pulse is honoured
  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    valido_d = valido_q;
    case (estado_q)
      CARGA_A: begin
        if (pulso_a) begin
          a_d      = bus.entrada;
          estado_d = CARGA_B;
        end
      end
      CARGA_B: begin
        if (pulso_b) begin
          b_d      = bus.entrada;
          estado_d = CARGA_OP;
        end
      end
      CARGA_OP: begin
        if (pulso_op) begin
          op_d     = bus.entrada[ANCHO_OP-1:0];
          estado_d = LISTO;
        end
      end
      LISTO: begin
        if (pulso_exec) begin
          estado_d = EJEC;
        end else if (pulso_a) begin
          a_d      = bus.entrada;
          estado_d = CARGA_B;
        end
      end
      EJEC: begin
        res_d    = bus.resultado_alu;
        valido_d = 1'b1;
        estado_d = MUESTRA;
      end
      MUESTRA: begin
        if (pulso_exec) begin
          valido_d = 1'b0;
          estado_d = EJEC;
        end else if (pulso_a) begin
          a_d      = bus.entrada;
          valido_d = 1'b0;
          estado_d = CARGA_B;
        end
      end
      default: begin
        estado_d = CARGA_A;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= CARGA_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      valido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      valido_q <= valido_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op        = op_q;
  assign bus.resultado = res_q;
  assign bus.valido    = valido_q;
  assign bus.estado    = estado_q;

endmodule

// File: tb/tb_secuenciador_alu.sv
// Scoreboard bench for secuenciador_alu: stimulus queues expected output
// snapshots with their arrival cycle; a monitor pops one per output change.
module tb_secuenciador_alu;
  localparam int W   = 8;
  localparam int WO  = 6;
  localparam int DEB = 16;
`ifdef DEBOUNCE_EN
  localparam int LAT  = 3 + DEB;
  localparam int HOLD = DEB + 3;
  localparam int GAP  = DEB + 4;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
  localparam int GAP  = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  secuenciador_alu_if #(.ANCHO(W), .ANCHO_OP(WO)) bus ();

  assign bus.resultado_alu = bus.a + bus.b;

  secuenciador_alu #(
    .ANCHO(W), .ANCHO_OP(WO), .DEB_CICLOS(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    logic       val;
    logic [2:0] est;
    int         at;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  logic [7:0] m_a, m_b, m_res;
  logic [5:0] m_op;
  logic       m_val;
  logic [2:0] m_est;

  function automatic logic [33:0] snap();
    return {bus.a, bus.b, bus.op, bus.resultado, bus.valido, bus.estado};
  endfunction

  function automatic logic [33:0] msnap();
    return {m_a, m_b, m_op, m_res, m_val, m_est};
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_val = 0; m_est = 0;
  endtask

  task automatic expect_at(input string n, input int at);
    exp_t e;
    e.name = n; e.a = m_a; e.b = m_b; e.op = m_op;
    e.res = m_res; e.val = m_val; e.est = m_est; e.at = at;
    q.push_back(e);
  endtask

  task automatic check_now(input string n);
    checks++;
    if (snap() !== msnap()) begin
      errors++;
      $display("FAIL %s: got {a,b,op,res,val,est}=%h want %h",
               n, snap(), msnap());
    end
  endtask

  task automatic drive(input logic [3:0] m);
    bus.boton_a    = m[0];
    bus.boton_b    = m[1];
    bus.boton_op   = m[2];
    bus.boton_exec = m[3];
  endtask

  task automatic start(input logic [3:0] m, input logic [7:0] v,
                       output int c);
    @(negedge clk);
    bus.entrada = v;
    drive(m);
    c = cyc;
  endtask

  task automatic rel(input int hold);
    repeat (hold) @(negedge clk);
    drive(4'b0000);
    repeat (GAP) @(negedge clk);
  endtask

  // Monitor: every output change must match the head of the queue
  initial begin
    logic [33:0] last;
    logic [33:0] cur;
    logic [33:0] want;
    exp_t        e;
    last = '0;
    forever begin
      @(negedge clk);
      cur = snap();
      if (mon_en && rst_n) begin
        if (cur !== last) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected: outputs became %h at cycle %0d",
                     cur, cyc);
          end else begin
            e = q.pop_front();
            want = {e.a, e.b, e.op, e.res, e.val, e.est};
            if (cur !== want || cyc != e.at) begin
              errors++;
              $display("FAIL %s: got %h at cycle %0d want %h at cycle %0d",
                       e.name, cur, cyc, want, e.at);
            end
          end
        end else if (q.size() != 0 && cyc > q[0].at) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL %s: no change by cycle %0d (due %0d), outputs %h",
                   e.name, cyc, e.at, cur);
        end
      end
      last = cur;
    end
  end

  initial begin
    int c;
    bus.entrada = 8'h00;
    drive(4'b0000);
    model_reset();
    repeat (3) @(negedge clk);
    check_now("reset_state");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    bus.entrada = 8'hAA;
    repeat (5) @(negedge clk);
    check_now("idle_switches");

    start(4'b1110, 8'h55, c);
    rel(HOLD);
    check_now("carga_a_ignores_b_op_exec");

    start(4'b0011, 8'h05, c);
    m_a = 8'h05; m_est = 3'd1;
    expect_at("load_a_with_b", c + LAT);
    rel(HOLD);

    start(4'b0010, 8'h03, c);
    m_b = 8'h03; m_est = 3'd2;
    expect_at("load_b", c + LAT);
    rel(HOLD);

    start(4'b0100, 8'h20, c);
    m_op = 6'h20; m_est = 3'd3;
    expect_at("load_op", c + LAT);
    rel(HOLD);

    start(4'b1000, 8'h00, c);
    m_est = 3'd4;
    expect_at("ejec", c + LAT);
    m_res = 8'h08; m_val = 1'b1; m_est = 3'd5;
    expect_at("muestra_sum", c + LAT + 1);
    rel(HOLD);
    check_now("after_exec");

    start(4'b0001, 8'h7F, c);
    m_a = 8'h7F; m_val = 1'b0; m_est = 3'd1;
    expect_at("muestra_load_a", c + LAT);
    rel(HOLD);

    start(4'b0010, 8'h10, c);
    m_b = 8'h10; m_est = 3'd2;
    expect_at("load_b2", c + LAT);
    rel(HOLD);

    start(4'b0100, 8'hFF, c);
    m_op = 6'h3F; m_est = 3'd3;
    expect_at("load_op_trunc", c + LAT);
    rel(HOLD);

    start(4'b0110, 8'h44, c);
    rel(HOLD);
    check_now("listo_ignores_b_op");

    start(4'b0001, 8'h11, c);
    m_a = 8'h11; m_est = 3'd1;
    expect_at("listo_restart_hold", c + LAT);
    repeat (LAT + 1) @(negedge clk);
    bus.entrada = 8'h22;
    rel(50 - LAT - 1);
    check_now("hold_a_single_load");

    start(4'b0010, 8'h22, c);
    m_b = 8'h22; m_est = 3'd2;
    expect_at("load_b3", c + LAT);
    rel(HOLD);

    start(4'b0100, 8'h01, c);
    m_op = 6'h01; m_est = 3'd3;
    expect_at("load_op3", c + LAT);
    rel(HOLD);

    start(4'b1000, 8'h00, c);
    m_est = 3'd4;
    expect_at("ejec2", c + LAT);
    m_res = 8'h33; m_val = 1'b1; m_est = 3'd5;
    expect_at("muestra_sum2", c + LAT + 1);
    rel(HOLD);

    start(4'b1000, 8'h00, c);
    m_val = 1'b0; m_est = 3'd4;
    expect_at("reexec_ejec", c + LAT);
    m_val = 1'b1; m_est = 3'd5;
    expect_at("reexec_muestra", c + LAT + 1);
    rel(HOLD);

    start(4'b1000, 8'h00, c);
    m_val = 1'b0; m_est = 3'd4;
    expect_at("ejec_before_rst", c + LAT);
    while (cyc < c + LAT) @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    drive(4'b0000);
    #1;
    model_reset();
    check_now("async_reset_mid_ejec");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    start(4'b0001, 8'h5A, c);
    m_a = 8'h5A; m_est = 3'd1;
    expect_at("load_a_after_rst", c + LAT);
    rel(HOLD);

`ifdef DEBOUNCE_EN
    @(negedge clk);
    bus.entrada = 8'h99;
    bus.boton_b = 1'b1;
    repeat (5) @(negedge clk);
    bus.boton_b = 1'b0;
    repeat (GAP) @(negedge clk);
    check_now("glitch_ignored");
`endif

    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: still pending at cycle %0d (due %0d)",
               e.name, cyc, e.at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
